sysctrl_mp: RTL and testbench

Parametrised successor to the MCU system-control endpoint. It decodes the SPI-derived MCU byte stream into commands and holds a generic indexed config register bank in place of hard-wired per-option outputs. It serves NPORTS byte-stream IO ports (serial, MIDI, ...) instead of one, and aggregates interrupts to the MCU. It sits between the MCU link deserialiser and the core's option/port consumers.

---
 rtl/sysctrl_pkg.sv | 40 ++++
 rtl/sysctrl_port_mux.sv | 68 ++++++
 rtl/sysctrl_mp.sv | 244 ++++++++++++++++++++++++
 tb/tb_sysctrl_mp.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sysctrl_pkg.sv
// sysctrl_pkg: shared command codes, port sub-commands and helpers for the
// multi-port MCU system-control endpoint.
package sysctrl_pkg;

   // Top-level command byte values sent after a start strobe.
   typedef enum logic [7:0] {
      CMD_STATUS    = 8'd0,
      CMD_LEDS      = 8'd1,
      CMD_COLOR     = 8'd2,
      CMD_RSVD3     = 8'd3,
      CMD_CFG_WRITE = 8'd4,
      CMD_INT_ACK   = 8'd5,
      CMD_PORT_INFO = 8'd6,
      CMD_PORT      = 8'd7,
      CMD_RSVD8     = 8'd8,
      CMD_CFG_READ  = 8'd9
   } cmd_e;

   // Sub-commands of CMD_PORT, carried in the first data byte.
   typedef enum logic [7:0] {
      PSUB_STATUS = 8'd0,
      PSUB_READ   = 8'd1,
      PSUB_WRITE  = 8'd2
   } psub_e;

   // Config index that addresses the main reset control instead of a register.
   localparam logic [7:0] CFG_IDX_RESET = 8'hFF;

   // Identification bytes returned by CMD_STATUS.
   localparam logic [7:0] STATUS_MAGIC0 = 8'h5C;
   localparam logic [7:0] STATUS_MAGIC1 = 8'h42;

   // The MCU sends colour bytes LSB-first relative to the ws2812 bit order.
   function automatic logic [7:0] bit_rev8(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = b[7-i];
      return r;
   endfunction

endpackage

// File: rtl/sysctrl_port_mux.sv
// sysctrl_port_mux: selects one IO port's status/data/available counts by
// index, drives the one-hot pop/push strobes and tracks per-port
// "bytes available" rising edges for the interrupt logic.
module sysctrl_port_mux #(
   parameter int NPORTS = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            idx,
   input  logic [NPORTS*32-1:0]  port_status,
   input  logic [NPORTS*8-1:0]   port_out_available,
   input  logic [NPORTS*8-1:0]   port_out_data,
   input  logic [NPORTS*8-1:0]   port_in_available,
   input  logic                  pop_req,
   input  logic                  push_req,
   output logic                  idx_valid,
   output logic [31:0]           sel_status,
   output logic [7:0]            sel_out_avail,
   output logic [7:0]            sel_out_data,
   output logic [7:0]            sel_in_avail,
   output logic [NPORTS-1:0]     avail_nz,
   output logic [NPORTS-1:0]     avail_rise,
   output logic [NPORTS-1:0]     port_out_strobe,
   output logic [NPORTS-1:0]     port_in_strobe
);

   logic [NPORTS-1:0] onehot;
   logic [NPORTS-1:0] avail_prev;

   // Index decode and per-port selection; out-of-range indexes select nothing.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      idx_valid     = 1'b0;
      onehot        = '0;
      sel_status    = '0;
      sel_out_avail = '0;
      sel_out_data  = '0;
      sel_in_avail  = '0;
      for (int p = 0; p < NPORTS; p++) begin
         avail_nz[p] = |port_out_available[8*p +: 8];
         if (idx == 8'(p)) begin
            idx_valid     = 1'b1;
            onehot[p]     = 1'b1;
            sel_status    = port_status[32*p +: 32];
            sel_out_avail = port_out_available[8*p +: 8];
            sel_out_data  = port_out_data[8*p +: 8];
            sel_in_avail  = port_in_available[8*p +: 8];
         end
      end
   end

   assign avail_rise = avail_nz & ~avail_prev;

   // Availability history and single-cycle registered FIFO strobes.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (reset) begin
         avail_prev      <= '0;
         port_out_strobe <= '0;
         port_in_strobe  <= '0;
      end else begin
         avail_prev      <= avail_nz;
         port_out_strobe <= pop_req  ? onehot : '0;
         port_in_strobe  <= push_req ? onehot : '0;
      end
   end

endmodule

// File: rtl/sysctrl_mp.sv
// sysctrl_mp: MCU system-control endpoint with an indexed config register
// bank, NPORTS byte-stream IO ports and interrupt aggregation.
// Optional build macro SYSCTRL_CFG_READBACK_EN adds CMD_CFG_READ readback.
module sysctrl_mp
   import sysctrl_pkg::*;
#(
   parameter int          NPORTS        = 2,
   parameter int          CFG_NUM       = 64,
   parameter logic [7:0]  CORE_ID       = 8'h00,
   parameter int unsigned RST_TIMEOUT   = 86_000_000,
   parameter logic [23:0] TIMEOUT_COLOR = 24'h000202
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  data_in_strobe,
   input  logic                  data_in_start,
   input  logic [7:0]            data_in,
   output logic [7:0]            data_out,
   output logic                  int_out_n,
   input  logic [7:0]            int_in,
   output logic [7:0]            int_ack,
   output logic [1:0]            leds,
   output logic [23:0]           color,
   output logic [1:0]            main_reset,
   output logic [CFG_NUM*8-1:0]  cfg_out,
   input  logic [NPORTS*32-1:0]  port_status,
   input  logic [NPORTS*8-1:0]   port_out_available,
   input  logic [NPORTS*8-1:0]   port_out_data,
   output logic [NPORTS-1:0]     port_out_strobe,
   input  logic [NPORTS*8-1:0]   port_in_available,
   output logic [7:0]            port_in_data,
   output logic [NPORTS-1:0]     port_in_strobe
);

   logic [7:0]  cmd;
   logic [3:0]  cnt;
   logic [7:0]  cfg_idx;
   logic [7:0]  port_sub;
   logic [7:0]  port_idx;
   logic [31:0] tmo;
   logic        coldboot;
   logic        sys_int;
   logic [7:0]  cfg [CFG_NUM];

   logic        start_en, byte_en;
   logic        cfg_hit, cfg_wr, reset_wr, tmo_expire;
   logic        port_data_phase, pop_req, push_req;
   logic [7:0]  avail_map;
   logic [7:0]  reply;

   logic              idx_valid;
   logic [31:0]       sel_status;
   logic [7:0]        sel_out_avail, sel_out_data, sel_in_avail;
   logic [NPORTS-1:0] avail_nz, avail_rise;

   sysctrl_port_mux #(.NPORTS(NPORTS)) u_port_mux (
      .clk                (clk),
      .reset              (reset),
      .idx                (port_idx),
      .port_status        (port_status),
      .port_out_available (port_out_available),
      .port_out_data      (port_out_data),
      .port_in_available  (port_in_available),
      .pop_req            (pop_req),
      .push_req           (push_req),
      .idx_valid          (idx_valid),
      .sel_status         (sel_status),
      .sel_out_avail      (sel_out_avail),
      .sel_out_data       (sel_out_data),
      .sel_in_avail       (sel_in_avail),
      .avail_nz           (avail_nz),
      .avail_rise         (avail_rise),
      .port_out_strobe    (port_out_strobe),
      .port_in_strobe     (port_in_strobe)
   );

   assign start_en  = data_in_strobe &  data_in_start;
   assign byte_en   = data_in_strobe & ~data_in_start;
   assign int_out_n = ~(sys_int | (|int_in));

   // Config index decode; a config register hit takes priority over the reset index.
   always_comb begin
      cfg_hit = 1'b0;
      for (int i = 0; i < CFG_NUM; i++)
         if (cfg_idx == 8'(i)) cfg_hit = 1'b1;
   end

   assign cfg_wr   = byte_en && (cmd == CMD_CFG_WRITE) && (cnt == 4'd1) && cfg_hit;
   assign reset_wr = byte_en && (cmd == CMD_CFG_WRITE) && (cnt == 4'd1) && !cfg_hit
                     && (cfg_idx == CFG_IDX_RESET);
   // An explicit reset write in the expiry cycle overrides the timeout.
   assign tmo_expire = (tmo == 32'd1) && !reset_wr;

   assign port_data_phase = byte_en && (cmd == CMD_PORT) && (cnt >= 4'd2) && idx_valid;
   assign pop_req  = port_data_phase && (port_sub == PSUB_READ) && data_in[0];
   assign push_req = port_data_phase && (port_sub == PSUB_WRITE);

`ifdef SYSCTRL_CFG_READBACK_EN
   logic [7:0] cfg_rd;

   // Readback mux; indexes beyond the bank read as zero.
   always_comb begin
      cfg_rd = '0;
      for (int i = 0; i < CFG_NUM; i++)
         if (cfg_idx == 8'(i)) cfg_rd = cfg[i];
   end
`endif

   // Per-port available bitmap padded to a byte.
   always_comb begin
      avail_map = '0;
      for (int p = 0; p < NPORTS; p++) avail_map[p] = avail_nz[p];
   end

   // Reply byte for the current (command, counter); registered on the data strobe.
   always_comb begin
      reply = 8'h00;
      case (cmd)
         CMD_STATUS: begin
            case (cnt)
               4'd0:    reply = STATUS_MAGIC0;
               4'd1:    reply = STATUS_MAGIC1;
               4'd2:    reply = CORE_ID;
               default: reply = 8'h00;
            endcase
         end
         CMD_INT_ACK: reply = {int_in[7:1], sys_int};
         CMD_PORT_INFO: begin
            if (cnt == 4'd0)      reply = {6'b0, |avail_nz, coldboot};
            else if (cnt == 4'd1) reply = avail_map;
         end
         CMD_PORT: begin
            if (cnt == 4'd0) reply = 8'(NPORTS);
            else if (cnt >= 4'd2 && idx_valid) begin
               if (port_sub == PSUB_STATUS) begin
                  case (cnt)
                     4'd2:    reply = sel_out_avail;
                     4'd3:    reply = sel_in_avail;
                     4'd4:    reply = sel_status[31:24];
                     4'd5:    reply = sel_status[23:16];
                     4'd6:    reply = sel_status[15:8];
                     4'd7:    reply = sel_status[7:0];
                     default: reply = 8'h00;
                  endcase
               end else if (port_sub == PSUB_READ) begin
                  reply = sel_out_data;
               end
            end
         end
`ifdef SYSCTRL_CFG_READBACK_EN
         CMD_CFG_READ: if (cnt != 4'd0) reply = cfg_rd;
`endif
         default: reply = 8'h00;
      endcase
   end

   // Config register bank.
   always_ff @(posedge clk) begin
      // NOTE: this is a flop bank, not a RAM, so clearing every entry on reset is intended.
      if (reset) begin
         for (int i = 0; i < CFG_NUM; i++) cfg[i] <= 8'h00;
      end else if (cfg_wr) begin
         for (int i = 0; i < CFG_NUM; i++)
            if (cfg_idx == 8'(i)) cfg[i] <= data_in;
      end
   end

   for (genvar i = 0; i < CFG_NUM; i++) begin : g_cfg_out
      assign cfg_out[8*i +: 8] = cfg[i];
   end

   // Command decoder, byte counter, timeout, interrupt flag and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         cmd          <= CMD_STATUS;
         cnt          <= '0;
         cfg_idx      <= '0;
         port_sub     <= '0;
         port_idx     <= '0;
         data_out     <= 8'h00;
         leds         <= 2'b00;
         color        <= '0;
         main_reset   <= 2'b11;
         tmo          <= 32'(RST_TIMEOUT);
         int_ack      <= '0;
         coldboot     <= 1'b1;
         sys_int      <= 1'b1;
         port_in_data <= '0;
      end else begin
         int_ack <= '0;

         if (tmo != 32'd0) tmo <= tmo - 32'd1;
         if (tmo_expire) begin
            main_reset <= 2'b00;
            color      <= TIMEOUT_COLOR;
         end

         if (|avail_rise)     sys_int <= 1'b1;
         else if (int_ack[0]) sys_int <= 1'b0;

         if (start_en) begin
            cmd      <= data_in;
            cnt      <= '0;
            data_out <= 8'h00;
         end else if (byte_en) begin
            data_out <= reply;
            if (cnt != 4'hF) cnt <= cnt + 4'd1;
            case (cmd)
               CMD_LEDS: if (cnt == 4'd0) leds <= data_in[1:0];
               CMD_COLOR: begin
                  case (cnt)
                     4'd0:    color[15:8]  <= bit_rev8(data_in);
                     4'd1:    color[7:0]   <= bit_rev8(data_in);
                     4'd2:    color[23:16] <= bit_rev8(data_in);
                     default: ;
                  endcase
               end
               CMD_CFG_WRITE: begin
                  if (cnt == 4'd0) cfg_idx <= data_in;
                  if (reset_wr) begin
                     main_reset <= data_in[1:0];
                     tmo        <= 32'd0;
                  end
               end
               CMD_INT_ACK:   if (cnt == 4'd0) int_ack <= data_in;
               CMD_PORT_INFO: if (cnt == 4'd0) coldboot <= 1'b0;
               CMD_PORT: begin
                  if (cnt == 4'd0) port_sub <= data_in;
                  if (cnt == 4'd1) port_idx <= data_in;
                  if (push_req)    port_in_data <= data_in;
               end
`ifdef SYSCTRL_CFG_READBACK_EN
               CMD_CFG_READ: begin
                  if (cnt == 4'd0) cfg_idx <= data_in;
                  else             cfg_idx <= cfg_idx + 8'd1;
               end
`endif
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sysctrl_mp.sv
// tb_sysctrl_mp: directed self-checking bench for sysctrl_mp
// (NPORTS=2, CFG_NUM=64, CORE_ID=A5, RST_TIMEOUT=100).
module tb_sysctrl_mp;

   localparam int NPORTS  = 2;
   localparam int CFG_NUM = 64;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 data_in_strobe = 1'b0;
   logic                 data_in_start = 1'b0;
   logic [7:0]           data_in = '0;
   logic [7:0]           data_out;
   logic                 int_out_n;
   logic [7:0]           int_in = '0;
   logic [7:0]           int_ack;
   logic [1:0]           leds;
   logic [23:0]          color;
   logic [1:0]           main_reset;
   logic [CFG_NUM*8-1:0] cfg_out;
   logic [NPORTS*32-1:0] port_status = '0;
   logic [NPORTS*8-1:0]  port_out_available = '0;
   logic [NPORTS*8-1:0]  port_out_data = '0;
   logic [NPORTS-1:0]    port_out_strobe;
   logic [NPORTS*8-1:0]  port_in_available = '0;
   logic [7:0]           port_in_data;
   logic [NPORTS-1:0]    port_in_strobe;

   int n_tests = 0;
   int n_fail  = 0;
   logic [CFG_NUM*8-1:0] exp_cfg;
   logic [7:0]           exp_rb;

   sysctrl_mp #(
      .NPORTS(NPORTS), .CFG_NUM(CFG_NUM), .CORE_ID(8'hA5),
      .RST_TIMEOUT(100), .TIMEOUT_COLOR(24'h000202)
   ) dut (
      .clk(clk), .reset(reset),
      .data_in_strobe(data_in_strobe), .data_in_start(data_in_start),
      .data_in(data_in), .data_out(data_out),
      .int_out_n(int_out_n), .int_in(int_in), .int_ack(int_ack),
      .leds(leds), .color(color), .main_reset(main_reset), .cfg_out(cfg_out),
      .port_status(port_status), .port_out_available(port_out_available),
      .port_out_data(port_out_data), .port_out_strobe(port_out_strobe),
      .port_in_available(port_in_available), .port_in_data(port_in_data),
      .port_in_strobe(port_in_strobe)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One MCU byte: strobe for the cycle starting at this negedge.
   task automatic send(input logic st, input logic [7:0] b);
      data_in_strobe = 1'b1;
      data_in_start  = st;
      data_in        = b;
      @(negedge clk);
      data_in_strobe = 1'b0;
      data_in_start  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] s0_rep [9];
      logic [7:0] p1_byte [5], p1_rep [5];
      logic [1:0] p1_stb [5];
      s0_rep  = '{8'h02, 8'h00, 8'h03, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
      p1_byte = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00};
      p1_rep  = '{8'h02, 8'h00, 8'h77, 8'h77, 8'h77};
      p1_stb  = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b00};

      // Reset values.
      repeat (3) @(negedge clk);
      check("rst data_out", data_out, 8'h00);
      check("rst leds", leds, 2'b00);
      check("rst color", color, 24'h0);
      check("rst main_reset", main_reset, 2'b11);
      check("rst int_ack", int_ack, 8'h00);
      check("rst strobes", {port_out_strobe, port_in_strobe}, 4'b0);
      check("rst int_out_n", int_out_n, 1'b0);
      check("rst cfg", cfg_out, '0);

      // Idle timeout expiry at cycle 100.
      reset = 1'b0;
      repeat (99) @(negedge clk);
      check("tmo c99 main_reset", main_reset, 2'b11);
      @(negedge clk);
      check("tmo c100 main_reset", main_reset, 2'b00);
      check("tmo c100 color", color, 24'h000202);

      // CMD4/FF at cycle 50 releases reset and cancels the timeout.
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (47) @(negedge clk);
      send(1'b1, 8'h04);
      send(1'b0, 8'hFF);
      send(1'b0, 8'h00);
      check("cmd4 ff main_reset", main_reset, 2'b00);
      repeat (60) @(negedge clk);
      check("cmd4 ff late main_reset", main_reset, 2'b00);
      check("cmd4 ff late color", color, 24'h0);

      // CMD0 status bytes.
      send(1'b1, 8'h00);
      check("cmd0 start", data_out, 8'h00);
      send(1'b0, 8'h00); check("cmd0 b0", data_out, 8'h5C);
      send(1'b0, 8'h00); check("cmd0 b1", data_out, 8'h42);
      send(1'b0, 8'h00); check("cmd0 b2", data_out, 8'hA5);

      // CMD1 leds and CMD2 bit-reversed colour.
      send(1'b1, 8'h01); send(1'b0, 8'hFE);
      check("cmd1 leds", leds, 2'b10);
      send(1'b1, 8'h02); send(1'b0, 8'h01); send(1'b0, 8'h03); send(1'b0, 8'h0F);
      check("cmd2 color", color, 24'hF080C0);

      // CMD4 config writes, including an out-of-range index.
      send(1'b1, 8'h04); send(1'b0, 8'h05); send(1'b0, 8'hA7);
      send(1'b1, 8'h04); send(1'b0, 8'h40); send(1'b0, 8'h11);
      send(1'b1, 8'h04); send(1'b0, 8'h3F); send(1'b0, 8'h5A);
      exp_cfg = '0;
      exp_cfg[47:40]   = 8'hA7;
      exp_cfg[511:504] = 8'h5A;
      check("cmd4 cfg", cfg_out, exp_cfg);
      check("cmd4 ignored idx main_reset", main_reset, 2'b00);

      // CMD5 ack clears sys_int.
      send(1'b1, 8'h05); send(1'b0, 8'h01);
      check("cmd5 int_ack", int_ack, 8'h01);
      check("cmd5 reply", data_out, 8'h01);
      @(negedge clk);
      check("cmd5 ack pulse end", int_ack, 8'h00);
      check("cmd5 int_out_n", int_out_n, 1'b1);
      int_in = 8'h80;
      #1 check("int_in drives int_out_n", int_out_n, 1'b0);
      int_in = 8'h00;

      // Rising availability on port 1 raises the interrupt.
      port_out_available = 16'h0300;
      @(negedge clk);
      check("avail rise int_out_n", int_out_n, 1'b0);

      // CMD6 port info.
      send(1'b1, 8'h06);
      send(1'b0, 8'h00); check("cmd6 b0", data_out, 8'h03);
      send(1'b0, 8'h00); check("cmd6 b1", data_out, 8'h02);
      send(1'b0, 8'h00); check("cmd6 b2", data_out, 8'h00);
      send(1'b1, 8'h06);
      send(1'b0, 8'h00); check("cmd6 coldboot cleared", data_out, 8'h02);

      // Clear, then a rising edge coincident with the ack keeps sys_int set.
      send(1'b1, 8'h05); send(1'b0, 8'h01);
      @(negedge clk);
      check("cmd5 second clear", int_out_n, 1'b1);
      send(1'b1, 8'h05); send(1'b0, 8'h01);
      port_out_available = 16'h0305;
      @(negedge clk);
      check("set beats clear", int_out_n, 1'b0);
      @(negedge clk);
      check("set beats clear hold", int_out_n, 1'b0);

      // CMD7 sub 0: port 1 status.
      port_status       = {32'hDEADBEEF, 32'h0};
      port_in_available = 16'h1000;
      send(1'b1, 8'h07);
      for (int i = 0; i < 9; i++) begin
         send(1'b0, (i == 1) ? 8'h01 : 8'h00);
         check($sformatf("cmd7 s0 b%0d", i), data_out, s0_rep[i]);
      end

      // CMD7 sub 1: pops follow data_in[0], head byte returned.
      port_out_data = {8'h77, 8'h11};
      send(1'b1, 8'h07);
      for (int i = 0; i < 5; i++) begin
         send(1'b0, p1_byte[i]);
         check($sformatf("cmd7 s1 reply b%0d", i), data_out, p1_rep[i]);
         check($sformatf("cmd7 s1 pop b%0d", i), port_out_strobe, p1_stb[i]);
      end

      // Out-of-range port index: zeros and no strobes.
      send(1'b1, 8'h07); send(1'b0, 8'h01); send(1'b0, 8'h05);
      for (int i = 0; i < 2; i++) begin
         send(1'b0, 8'h01);
         check($sformatf("cmd7 bad idx reply b%0d", i), data_out, 8'h00);
         check($sformatf("cmd7 bad idx pop b%0d", i), port_out_strobe, 2'b00);
      end

      // CMD7 sub 2: push to port 0.
      send(1'b1, 8'h07); send(1'b0, 8'h02); send(1'b0, 8'h00); send(1'b0, 8'h9C);
      check("cmd7 s2 push", port_in_strobe, 2'b01);
      check("cmd7 s2 data", port_in_data, 8'h9C);
      @(negedge clk);
      check("cmd7 s2 push end", port_in_strobe, 2'b00);

      // CMD9 readback (unknown command when the feature is not built).
`ifdef SYSCTRL_CFG_READBACK_EN
      exp_rb = 8'h5A;
`else
      exp_rb = 8'h00;
`endif
      send(1'b1, 8'h09);
      send(1'b0, 8'h3F); check("cmd9 b0", data_out, 8'h00);
      send(1'b0, 8'h00); check("cmd9 b1", data_out, exp_rb);
      send(1'b0, 8'h00); check("cmd9 b2", data_out, 8'h00);

      // Reset mid-transaction: next data byte is CMD0 counter 0.
      send(1'b1, 8'h01);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      send(1'b0, 8'h03);
      check("abort reply", data_out, 8'h5C);
      check("abort leds", leds, 2'b00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
